// File: rtl/stream_upsizer_pkg.sv
// rtl/stream_upsizer_pkg.sv - shared stream beat type and sizing helpers
package stream_upsizer_pkg;

  // Default byte-wide beat as seen on producer streams feeding the FIFO path.
  localparam int STREAM_BEAT_W = 8;

  typedef struct packed {
    logic [STREAM_BEAT_W-1:0] data;
    logic                     last;
  } stream_beat_t;

  // Number of bits needed to index RATIO lanes (RATIO is a power of 2).
  function automatic int log2_ratio(input int ratio);
    int n;
    int v;
    n = 0;
    v = ratio;
    while (v > 1) begin
      v = v >> 1;
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/stream_upsizer.sv
// rtl/stream_upsizer.sv - packs RATIO narrow beats into one wide word with lane keep mask
module stream_upsizer
  import stream_upsizer_pkg::*;
#(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4,
  parameter int TIMEOUT  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_WIDTH-1:0]       in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IN_WIDTH*RATIO-1:0] out_data,
  output logic [RATIO-1:0]          out_keep,
  output logic                      out_last
);

  localparam int CW = (log2_ratio(RATIO) < 1) ? 1 : log2_ratio(RATIO);
  localparam int OW = IN_WIDTH * RATIO;
  localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

  // Reject parameter sets the lane indexing cannot represent.
  if ((RATIO < 2) || ((RATIO & (RATIO - 1)) != 0)) begin : g_bad_ratio
    $fatal(1, "stream_upsizer: RATIO must be a power of 2 and at least 2");
  end
  if (IN_WIDTH < 1) begin : g_bad_width
    $fatal(1, "stream_upsizer: IN_WIDTH must be at least 1");
  end

  // Lane accumulator and fill state.
  logic [RATIO-1:0][IN_WIDTH-1:0] r_acc;
  logic [RATIO-1:0]               r_keep;
  logic [CW-1:0]                  r_cnt;

  // Output register presented to the FIFO write port.
  logic [OW-1:0]                  r_out_data;
  logic [RATIO-1:0]               r_out_keep;
  logic                           r_out_last;
  logic                           r_out_valid;

  logic                           w_free;
  logic                           w_in_hs;
  logic                           w_complete;
  logic                           w_flush;
  logic                           w_load;
  logic [RATIO-1:0][IN_WIDTH-1:0] w_acc_next;
  logic [RATIO-1:0]               w_keep_next;
  logic [OW-1:0]                  w_load_data;
  logic [RATIO-1:0]               w_load_keep;
  logic                           w_load_last;

  // The output slot is free when empty or being drained this cycle; in_ready
  // never looks at in_valid so upstream cannot form a combinational loop.
  assign w_free     = !r_out_valid || out_ready;
  assign w_in_hs    = in_valid && w_free;
  assign w_complete = w_in_hs && ((r_cnt == LAST_LANE) || in_last);
  assign w_load     = w_complete || w_flush;

  // Accumulator as it would look with the current beat merged into lane cnt.
  always_comb begin
    w_acc_next         = r_acc;
    w_keep_next        = r_keep;
    w_acc_next[r_cnt]  = in_data;
    w_keep_next[r_cnt] = 1'b1;
  end

  // A completing beat emits the merged word; a flush emits the partial word as-is.
  assign w_load_data = w_complete ? OW'(w_acc_next)  : OW'(r_acc);
  assign w_load_keep = w_complete ? w_keep_next      : r_keep;
  assign w_load_last = w_complete && in_last;

  // Idle timer only exists when a timeout is configured.
  if (TIMEOUT > 0) begin : g_timeout
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);

    logic [TW-1:0] r_timer;

    // Count idle cycles while a partial word sits in the accumulator; hold at
    // the limit so a flush blocked by backpressure fires as soon as the slot frees.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_timer <= '0;
      end else if (w_in_hs || (r_cnt == '0) || w_flush) begin
        r_timer <= '0;
      end else if (r_timer != TIMEOUT_V) begin
        r_timer <= r_timer + TW'(1);
      end
    end

    // An accepted beat in the expiry cycle takes priority over the flush.
    assign w_flush = (r_timer == TIMEOUT_V) && (r_cnt != '0) && !w_in_hs && w_free;
  end else begin : g_no_timeout
    assign w_flush = 1'b0;
  end

  // Fill lanes from lane 0 upward and clear everything once a word is emitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_keep <= '0;
      r_cnt  <= '0;
    end else if (w_load) begin
      r_acc  <= '0;
      r_keep <= '0;
      r_cnt  <= '0;
    end else if (w_in_hs) begin
      r_acc  <= w_acc_next;
      r_keep <= w_keep_next;
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  // Output register: a new load replaces a draining word without a bubble;
  // otherwise the word is held stable until out_ready takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_data  <= w_load_data;
      r_out_keep  <= w_load_keep;
      r_out_last  <= w_load_last;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_free;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_keep  = r_out_keep;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_stream_upsizer.sv
// tb/tb_stream_upsizer.sv - directed and randomized checks of stream_upsizer
module tb_stream_upsizer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  // DUT without timeout
  logic        in_valid, in_ready, in_last;
  logic [7:0]  in_data;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic [3:0]  out_keep;

  // DUT with TIMEOUT = 8
  logic        t_in_valid, t_in_ready, t_in_last;
  logic [7:0]  t_in_data;
  logic        t_out_valid, t_out_ready, t_out_last;
  logic [31:0] t_out_data;
  logic [3:0]  t_out_keep;

  stream_upsizer #(.IN_WIDTH(8), .RATIO(4), .TIMEOUT(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last)
  );

  stream_upsizer #(.IN_WIDTH(8), .RATIO(4), .TIMEOUT(8)) dut_to (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (t_in_valid),
    .in_ready  (t_in_ready),
    .in_data   (t_in_data),
    .in_last   (t_in_last),
    .out_valid (t_out_valid),
    .out_ready (t_out_ready),
    .out_data  (t_out_data),
    .out_keep  (t_out_keep),
    .out_last  (t_out_last)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic t_beat(input logic [7:0] d);
    t_in_valid = 1'b1;
    t_in_data  = d;
    t_in_last  = 1'b0;
    tick();
    t_in_valid = 1'b0;
  endtask

  // Reference model state for the randomized run
  logic [31:0] m_acc;
  logic [3:0]  m_keep;
  int          m_cnt;
  logic        m_ov;
  logic        m_load;
  logic [36:0] exp_q[$];
  logic [36:0] e;
  int          acc_beats;
  int          out_beats;
  int          cyc;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    t_in_valid = 1'b0; t_in_data = '0; t_in_last = 1'b0; t_out_ready = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_out_keep",  out_keep,  0);
    check("rst_out_last",  out_last,  0);
    check("rst_in_ready",  in_ready,  1);

    // Full word, single-cycle valid
    beat(8'h11, 0); beat(8'h22, 0); beat(8'h33, 0); beat(8'h44, 0);
    check("full_valid", out_valid, 1);
    check("full_data",  out_data,  32'h44332211);
    check("full_keep",  out_keep,  4'hF);
    check("full_last",  out_last,  0);
    tick();
    check("full_valid_once", out_valid, 0);

    // Short packet closed by in_last, then in_last on lane 0
    beat(8'hAA, 0); beat(8'hBB, 1);
    check("short_valid", out_valid, 1);
    check("short_data",  out_data,  32'h0000BBAA);
    check("short_keep",  out_keep,  4'h3);
    check("short_last",  out_last,  1);
    beat(8'hCC, 1);
    check("lane0_valid", out_valid, 1);
    check("lane0_data",  out_data,  32'h000000CC);
    check("lane0_keep",  out_keep,  4'h1);
    check("lane0_last",  out_last,  1);
    tick();

    // Backpressure: input stalls while the word is held stable
    beat(8'h01, 0); beat(8'h02, 0); beat(8'h03, 0); beat(8'h04, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h05;
      #1;
      check("bp_in_ready",  in_ready,  0);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data",  out_data,  32'h04030201);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    beat(8'h05, 0); beat(8'h06, 0); beat(8'h07, 0); beat(8'h08, 0);
    check("bp_next_valid", out_valid, 1);
    check("bp_next_data",  out_data,  32'h08070605);
    check("bp_next_keep",  out_keep,  4'hF);
    tick();

    // Reset mid-word discards the partial word
    beat(8'h31, 0); beat(8'h32, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rstmid_valid", out_valid, 0);
    beat(8'h41, 0); beat(8'h42, 0); beat(8'h43, 0); beat(8'h44, 0);
    check("rstmid_data", out_data, 32'h44434241);
    check("rstmid_keep", out_keep, 4'hF);
    check("rstmid_last", out_last, 0);
    tick();

    // Timeout flush: beat at edge N, flush loads at edge N+9
    t_beat(8'h5A);
    repeat (8) tick();
    check("to_not_early", t_out_valid, 0);
    tick();
    check("to_valid", t_out_valid, 1);
    check("to_data",  t_out_data,  32'h0000005A);
    check("to_keep",  t_out_keep,  4'h1);
    check("to_last",  t_out_last,  0);
    tick();
    check("to_drained", t_out_valid, 0);

    // Beat at N+8 restarts the timer; beat in the expiry cycle wins over flush
    t_beat(8'h5A);
    repeat (7) tick();
    t_beat(8'h6B);
    tick();
    check("to_no_flush", t_out_valid, 0);
    repeat (7) tick();
    t_beat(8'h7C);
    check("to_beat_wins", t_out_valid, 0);
    repeat (8) tick();
    check("to2_not_early", t_out_valid, 0);
    tick();
    check("to2_valid", t_out_valid, 1);
    check("to2_data",  t_out_data,  32'h007C6B5A);
    check("to2_keep",  t_out_keep,  4'h7);
    check("to2_last",  t_out_last,  0);
    tick();

    // Randomized traffic against a reference model
    m_acc = '0; m_keep = '0; m_cnt = 0; m_ov = out_valid;
    acc_beats = 0; out_beats = 0; cyc = 0;
    while (acc_beats < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 8'($urandom_range(0, 255));
      in_last   = (acc_beats == 9999) ? 1'b1 : ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      check("rnd_in_ready",  in_ready,  (!m_ov || out_ready));
      check("rnd_out_valid", out_valid, m_ov);
      m_load = 1'b0;
      if (out_valid && out_ready) begin
        check("rnd_word_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("rnd_word", {out_data, out_keep, out_last}, e);
          out_beats += $countones(out_keep);
        end
      end
      if (in_valid && in_ready) begin
        m_acc[m_cnt*8 +: 8] = in_data;
        m_keep[m_cnt] = 1'b1;
        acc_beats++;
        if (m_cnt == 3 || in_last) begin
          exp_q.push_back({m_acc, m_keep, in_last});
          m_acc = '0; m_keep = '0; m_cnt = 0;
          m_load = 1'b1;
        end else begin
          m_cnt++;
        end
      end
      if (m_load) m_ov = 1'b1;
      else if (out_ready) m_ov = 1'b0;
      tick();
      cyc++;
    end
    check("rnd_beats_accepted", acc_beats, 10000);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (out_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rnd_tail_word", {out_data, out_keep, out_last}, e);
        out_beats += $countones(out_keep);
      end
      tick();
    end
    check("rnd_queue_empty", exp_q.size(), 0);
    check("rnd_beats_out",   out_beats,    10000);
    check("rnd_idle_valid",  out_valid,    0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stream_upsizer.md
# stream_upsizer

Single-clock valid/ready width converter that packs RATIO narrow input beats into one wide output word with a per-lane keep mask. It sits directly upstream of the async FIFO write port (w_valid/w_ready/w_data) and widens a byte-oriented producer stream before the clock-domain crossing, so the FIFO is written at 1/RATIO of the input beat rate. An optional idle timeout flushes partially filled words so that low-rate traffic is not stranded.

## Interface
- IN_WIDTH, default 8: width of one input beat / output lane.
- RATIO, default 4: lanes per output word; power of 2, ≥2.
- TIMEOUT, default 0: idle cycles before a partial word is flushed; 0 disables the timeout.
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when high together with in_valid.
- in_data  input  IN_WIDTH  input beat payload.
- in_last  input  1  marks the final beat of a packet; forces word emission.
- out_valid  output  1  output word valid; drives FIFO w_valid.
- out_ready  input  1  downstream accept; driven by FIFO w_ready.
- out_data  output  IN_WIDTH*RATIO  packed word; lane k = bits [k*IN_WIDTH +: IN_WIDTH].
- out_keep  output  RATIO  lane k holds valid data.
- out_last  output  1  word closes a packet (carries in_last).

## Operation
- State: lane accumulator acc (RATIO lanes), lane count cnt (0..RATIO-1), keep mask, output register (out_data/out_keep/out_last/out_valid), idle timer.
- Output slot free: free = !out_valid || out_ready. in_ready = free; it depends only on registered state and out_ready, never on in_valid.
- Input handshake (in_valid && in_ready):
  - the beat is written to lane cnt; keep[cnt] is set;
  - if cnt == RATIO-1 or in_last: the output register loads {acc with this beat, keep, in_last}; acc, keep and cnt are cleared; out_valid is set;
  - otherwise cnt increments.
- Unfilled lanes of an emitted word read 0 in out_data and 0 in out_keep. Lanes fill from lane 0 upward (little-endian).
- Output handshake (out_valid && out_ready) with no new load: out_valid clears. Load and drain in the same cycle: the new word replaces the old one and out_valid stays 1.
- Timeout (TIMEOUT > 0):
  - The timer resets to 0 on any input handshake or when cnt == 0.
  - Otherwise it increments each cycle and saturates at TIMEOUT.
  - Flush condition: timer == TIMEOUT, cnt != 0, no input handshake this cycle, and free.
  - On flush, the output register loads the partial word with out_last = 0; acc and cnt are cleared.
  - If free is low at expiry, the flush waits; the timer holds at TIMEOUT.
- Simultaneous input beat and timer expiry: the beat wins, the timer resets, and no flush occurs.
- in_last on lane 0 emits a one-lane word with keep = 1.
- Reset mid-word: the partial word and any pending output are discarded without emission.

## Timing
- Reset values: out_valid 0, out_data 0, out_keep 0, out_last 0, cnt 0, acc 0, timer 0. in_ready reads 1 in the first cycle after reset.
- Latency: the completing beat is accepted at edge N; out_valid is high from the cycle after edge N.
- Throughput: with out_ready held high, one beat is accepted every cycle and one word is emitted every RATIO cycles, with no bubbles.
- Backpressure: while out_valid && !out_ready, in_ready is 0, so accumulation stalls as well. out_data, out_keep and out_last are held stable.
- Timeout: the last beat is accepted at edge N, with no further input and free held high. The flush loads at edge N+TIMEOUT+1, and out_valid is high after that edge.

## Structure
- Single module, no sub-module; the datapath is too small to justify one.
- Shared stream package: a stream_beat_t typedef (data, last) and a helper function computing log2(RATIO) for the cnt width.
- Static checks at elaboration: $fatal(1, ...) if RATIO is not a power of 2 or is below 2, or if IN_WIDTH < 1.

## Test plan
- RATIO=4, out_ready=1: beats 0x11,0x22,0x33,0x44 on consecutive cycles, in_last=0 → one word: out_data 0x44332211, out_keep 0xF, out_last 0, out_valid for exactly 1 cycle.
- Beats 0xAA, then 0xBB with in_last=1 → out_data 0x0000BBAA, out_keep 0x3, out_last 1. The next beat 0xCC lands in lane 0.
- Backpressure: out_ready=0 for 10 cycles after a full word → in_ready=0 for those 10 cycles and out_data is stable. When out_ready rises, the word drains and the next 4 beats produce a second word with no lost beat.
- TIMEOUT=8: one beat 0x5A accepted at edge N, then idle → out_valid high after edge N+9 with out_data 0x0000005A, keep 0x1, last 0. A repeat with a beat at edge N+8 → no flush, and cnt becomes 2.
- Reset mid-word: 2 beats accepted, then rst=1 for 1 cycle → out_valid 0, and the next 4 beats form a clean word with keep 0xF.
- Random in_valid/out_ready (10k beats, random in_last) against a reference model → byte order, keep, last and beat count match; no duplicated or dropped beats.
